// File: rtl/mem_arbiter.sv
// Two-requestor (fetch/data) arbiter in front of a single-port 256x16 RAM.
// Ports: clk/clr, fetch req/adrs/ack, data req/we/adrs/wdata/ack, rdata, busy, RAM rw/adrs/din/dout.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_adrs,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adrs,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] rdata,
    output logic              busy,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_adrs,
    output logic [DATA_W-1:0] ram_din,
    input  logic [WORD_W-1:0] ram_dout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic              last_d;   // last grant went to data
    logic              cur_d;    // current transaction belongs to data
    logic [ADDR_W-1:0] adrs_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic any_req;
    logic win_d;
    logic grant;

    // On contention the requestor that did not win last time goes next.
    assign any_req = f_req | d_req;
    assign win_d   = d_req & (~f_req | ~last_d);
    assign grant   = any_req & ((state == IDLE) | (state == RESP));

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            cur_d   <= 1'b0;
            adrs_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            unique case (state)
                ACCESS: begin
                    rdata <= ram_dout;
                    state <= RESP;
                end
                IDLE, RESP: begin
                    state <= grant ? ACCESS : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (grant) begin
                last_d  <= win_d;
                cur_d   <= win_d;
                adrs_q  <= win_d ? d_adrs : f_adrs;
                we_q    <= win_d & d_we;
                wdata_q <= win_d ? d_wdata : '0;
            end
        end
    end

    assign f_ack    = (state == RESP) & ~cur_d;
    assign d_ack    = (state == RESP) & cur_d;
    assign busy     = (state == ACCESS) | (state == RESP);
    // Gated by clr so a reset edge during ACCESS never commits a write.
    assign ram_rw   = (state == ACCESS) & we_q & ~clr;
    assign ram_adrs = adrs_q;
    assign ram_din  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a behavioural 256x16 RAM.
// One table row per clock: inputs driven and outputs compared mid-cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        f_req, d_req, d_we;
    logic [7:0]  f_adrs, d_adrs, d_wdata;
    logic        f_ack, d_ack, busy, ram_rw;
    logic [15:0] rdata, ram_dout;
    logic [7:0]  ram_adrs, ram_din;
    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_rw) mem[ram_adrs] <= {8'h00, ram_din};
    assign ram_dout = mem[ram_adrs];

    mem_arbiter dut (
        .clk(clk), .clr(clr),
        .f_req(f_req), .f_adrs(f_adrs), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_adrs(d_adrs),
        .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy),
        .ram_rw(ram_rw), .ram_adrs(ram_adrs),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct {
        logic        clr, fr, dr, we;
        logic [7:0]  fa, da, wd;
        logic        chk, ef, ed, eb, erw;
        logic [15:0] erd;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic c, fr, input logic [7:0] fa,
                     input logic dr, we, input logic [7:0] da, wd,
                     input logic chk, ef, ed, eb, erw,
                     input logic [15:0] erd);
        vec_t r;
        r.clr = c; r.fr = fr; r.fa = fa; r.dr = dr; r.we = we;
        r.da = da; r.wd = wd; r.chk = chk; r.ef = ef; r.ed = ed;
        r.eb = eb; r.erw = erw; r.erd = erd;
        tbl.push_back(r);
    endtask

    task automatic cmp(input string nm, input int row,
                       input logic [15:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h5A, i[7:0]};
        mem[8'h10] = 16'h00A5;
        clr = 1; f_req = 0; d_req = 0; d_we = 0;
        f_adrs = 0; d_adrs = 0; d_wdata = 0;

        //  clr fr fa     dr we da     wd     chk f d b rw rdata
        // reset
        v(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0,0,0,0, 16'h0000);
        v(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h0000);
        // single load of 0x10
        v(0, 0, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0,0,0,0, 16'h0000);
        v(0, 0, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0,0,1,0, 16'h0000);
        v(0, 0, 8'h00, 0, 0, 8'h10, 8'h00, 1, 0,1,1,0, 16'h00A5);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h00A5);
        // store 0x3C to 0xFF, then fetch it back
        v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h3C, 1, 0,0,0,0, 16'h00A5);
        v(0, 0, 8'h00, 1, 1, 8'hFF, 8'h3C, 1, 0,0,1,1, 16'h00A5);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,1,1,0, 16'h5AFF);
        v(0, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h5AFF);
        v(0, 1, 8'hFF, 0, 0, 8'h00, 8'h00, 1, 0,0,1,0, 16'h5AFF);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1,0,1,0, 16'h003C);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h003C);
        // contention from reset: data, fetch, data, fetch
        v(1, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,0,0, 16'h003C);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,0,0, 16'h0000);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,1,0, 16'h0000);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,1,1,0, 16'h5A02);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,1,0, 16'h5A02);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 1,0,1,0, 16'h5A01);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,1,0, 16'h5A01);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,1,1,0, 16'h5A02);
        v(0, 1, 8'h01, 1, 0, 8'h02, 8'h00, 1, 0,0,1,0, 16'h5A02);
        v(0, 0, 8'h01, 0, 0, 8'h02, 8'h00, 1, 1,0,1,0, 16'h5A01);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h5A01);
        // back-to-back fetches of 0,1,2
        v(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h5A01);
        v(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,1,0, 16'h5A01);
        v(0, 1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 1,0,1,0, 16'h5A00);
        v(0, 1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0,0,1,0, 16'h5A00);
        v(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 1, 1,0,1,0, 16'h5A01);
        v(0, 1, 8'h02, 0, 0, 8'h00, 8'h00, 1, 0,0,1,0, 16'h5A01);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1,0,1,0, 16'h5A02);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h5A02);
        // store to 0x10 killed by reset on its ACCESS-exit edge
        v(0, 0, 8'h00, 1, 1, 8'h10, 8'h77, 1, 0,0,0,0, 16'h5A02);
        v(1, 0, 8'h00, 1, 1, 8'h10, 8'h77, 1, 0,0,1,0, 16'h5A02);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h0000);
        v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0,0,0,0, 16'h0000);

        foreach (tbl[i]) begin
            @(negedge clk);
            clr = tbl[i].clr; f_req = tbl[i].fr; f_adrs = tbl[i].fa;
            d_req = tbl[i].dr; d_we = tbl[i].we;
            d_adrs = tbl[i].da; d_wdata = tbl[i].wd;
            #1;
            if (tbl[i].chk) begin
                cmp("f_ack", i, {15'd0, f_ack}, {15'd0, tbl[i].ef});
                cmp("d_ack", i, {15'd0, d_ack}, {15'd0, tbl[i].ed});
                cmp("busy", i, {15'd0, busy}, {15'd0, tbl[i].eb});
                cmp("ram_rw", i, {15'd0, ram_rw}, {15'd0, tbl[i].erw});
                cmp("rdata", i, rdata, tbl[i].erd);
            end
        end

        cmp("mem_10_kept", 0, mem[8'h10], 16'h00A5);
        cmp("mem_FF_store", 0, mem[8'hFF], 16'h003C);

        // idle quiet for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clr = 0; f_req = 0; d_req = 0;
            #1;
            cmp("idle_busy", k, {15'd0, busy}, 16'd0);
            cmp("idle_rw", k, {15'd0, ram_rw}, 16'd0);
            cmp("idle_acks", k, {14'd0, f_ack, d_ack}, 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    always @(negedge clk)
        if (f_ack && d_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_overlap: got 11 want not both");
        end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requestor memory controller sitting directly upstream of the single-port 256x16 RAM.
- Arbitrates between instruction fetch (read-only) and data load/store requests.
- Drives the RAM's rw/adrs/din; registers the RAM's combinational read word back to the winning requestor with a one-cycle ack pulse.
- RAM timing it drives: writes commit on posedge clk while rw=1; stores {8'h00, din}; dout = mem[adrs] combinationally.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, write data width (RAM din)
WORD_W, 16, read word width (RAM dout)

Ports:
clk  in  1  system clock, all logic on rising edge
clr  in  1  reset, synchronous, active-high
f_req  in  1  fetch request, level, held until f_ack
f_adrs  in  ADDR_W  fetch address
f_ack  out  1  fetch done, one-cycle pulse, rdata valid
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=store, 0=load
d_adrs  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  data done, one-cycle pulse, rdata valid
rdata  out  WORD_W  registered read word, shared by both requestors
busy  out  1  high in ACCESS or RESP
ram_rw  out  1  to RAM rw
ram_adrs  out  ADDR_W  to RAM adrs
ram_din  out  DATA_W  to RAM din
ram_dout  in  WORD_W  from RAM dout

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (clr high at an edge):
  - state=IDLE; f_ack=d_ack=0; rdata=0; latched adrs/we/wdata=0; last_grant=FETCH.
  - ram_rw forced 0 combinationally while clr=1, so no write commits on a reset edge, even mid-ACCESS.
  - An in-flight transaction is dropped with no ack.
- IDLE:
  - If any req is high at an edge: arbitrate, latch the winner's adrs/we/wdata (fetch: we=0, wdata=0), go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration (shared by IDLE and RESP exits):
  - Only one req high: that requestor wins.
  - Both high: winner is the one not equal to last_grant. After reset, data wins first.
  - last_grant updates to the winner on every grant.
- ACCESS (exactly one cycle):
  - ram_adrs = latched adrs; ram_din = latched wdata; ram_rw = latched we & ~clr.
  - At the exiting edge: RAM commits any write; rdata <= ram_dout (for a store this is the pre-write word); go to RESP.
- RESP (one cycle):
  - Winner's ack=1; the other ack=0.
  - Exit edge: if any req is high, arbitrate and go directly to ACCESS (back-to-back); else IDLE.
  - A req still high on the edge ending RESP counts as a NEW request. A requestor wanting one transfer must drop req combinationally on seeing ack.
- Outside ACCESS: ram_rw=0; ram_adrs/ram_din hold the last latched values.
- rdata holds its value until the next ACCESS exit.
- Latency: req sampled at edge E0 -> ACCESS during E0..E1 -> ack high E1..E2. Ack arrives 2 cycles after sampling; peak throughput is one transfer per 2 cycles.
- f_ack and d_ack are never high together; neither is ever high in IDLE or ACCESS.
- Request inputs are only sampled at IDLE/RESP exit edges. Changes to adrs/we/wdata during ACCESS/RESP do not affect the current transfer.
- Address wrap: none needed; the full 0..255 range is valid, including 8'hFF.

Test Plan:
- Single load: preload mem[8'h10]=16'h00A5; d_req=1, d_we=0, d_adrs=8'h10 -> d_ack pulse 2 cycles after sampling, rdata=16'h00A5, f_ack stays 0.
- Store then fetch: store d_adrs=8'hFF, d_wdata=8'h3C (d_ack rdata = old word); then fetch f_adrs=8'hFF -> rdata=16'h003C. ram_rw high only during the store's ACCESS cycle.
- Contention: f_req and d_req both held high from reset for 4 transfers -> grant order data, fetch, data, fetch. Acks 2 cycles apart, never overlapping.
- Back-to-back: f_req held high continuously, addresses 0,1,2 presented after each ack -> f_ack every 2nd cycle; rdata sequence = mem[0], mem[1], mem[2]; busy stays high.
- Reset mid-write: store issued, clr=1 on the ACCESS-exit edge -> target word unchanged, no d_ack; state IDLE; rdata=0; ram_rw=0 during the clr cycle.
- Idle quiet: no req for 10 cycles -> busy=0, ram_rw=0, both acks 0.
